// File: rtl/motor_pkg.sv
// Shared definitions for the motor drive path.
//  - H-bridge IN pin encodings (fwd / rev / off)
//  - per-channel ramp state enum
//  - navigation mode codes shared with the nav FSM
package motor_pkg;

  localparam logic [1:0] IN_FWD = 2'b10;
  localparam logic [1:0] IN_REV = 2'b01;
  localparam logic [1:0] IN_OFF = 2'b00;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DECEL = 2'd1,
    DEAD  = 2'd2
  } chan_state_e;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_FWD   = 2'd1,
    MODE_REV   = 2'd2,
    MODE_TURN  = 2'd3
  } nav_mode_e;

  // Bridge encoding for an energised channel; dir=1 is forward.
  function automatic logic [1:0] in_enc(input logic dir);
    return dir ? IN_FWD : IN_REV;
  endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: slew-limited duty ramp plus safe direction reversal
// (decelerate to 0, hold the bridge off for DEAD_TICKS ticks, re-energise).
// Ports:
//  clk, rst     clock, async active-high reset
//  en           drive enable; 0 forces duty to 0 on the next edge
//  tick         1-cycle ramp tick from the shared prescaler
//  target_duty  requested duty (clamped to MAX_DUTY internally)
//  target_dir   requested direction, 1 = forward
//  duty         registered ramped duty
//  in_pair      registered H-bridge IN pins
//  settled      registered: RUN, duty at target, direction at target, enabled
module motor_ramp_chan
  import motor_pkg::*;
#(
  parameter int DUTY_W     = 10,
  parameter int MAX_DUTY   = 1023,
  parameter int STEP       = 10,
  parameter int DEAD_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_dir,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        in_pair,
  output logic              settled
);

  localparam int CW = $clog2(DEAD_TICKS + 1);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(STEP);

  chan_state_e       state, state_nxt;
  logic              cur_dir, cur_dir_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic [CW-1:0]     dcnt, dcnt_nxt;
  logic [DUTY_W-1:0] tgt;

  assign tgt = (target_duty > MAX_D) ? MAX_D : target_duty;

  // One ramp step from cur toward dst. The extra bit keeps the difference
  // and the +/- STEP intermediate from wrapping at either end of the range.
  function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] dst);
    logic [DUTY_W:0] a, b, diff, res;
    a    = {1'b0, cur};
    b    = {1'b0, dst};
    diff = (a >= b) ? (a - b) : (b - a);
    if (diff <= STEP_X) res = b;
    else if (a > b)     res = a - STEP_X;
    else                res = a + STEP_X;
    return res[DUTY_W-1:0];
  endfunction

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statements leaves one unassigned and infers a latch.
    state_nxt   = state;
    cur_dir_nxt = cur_dir;
    duty_nxt    = duty;
    dcnt_nxt    = dcnt;

    // A disabled channel only advances a dead time already in progress.
    if (tick && (en || state == DEAD)) begin
      unique case (state)
        RUN: begin
          if (target_dir == cur_dir) begin
            duty_nxt = ramp_to(duty, tgt);
          end else if (duty == '0) begin
            state_nxt = DEAD;
            dcnt_nxt  = CW'(DEAD_TICKS);
          end else begin
            state_nxt = DECEL;
          end
        end
        DECEL: begin
          if (target_dir == cur_dir) begin
            state_nxt = RUN;
          end else begin
            duty_nxt = ramp_to(duty, '0);
            if (duty_nxt == '0) begin
              state_nxt = DEAD;
              dcnt_nxt  = CW'(DEAD_TICKS);
            end
          end
        end
        DEAD: begin
          dcnt_nxt = dcnt - 1'b1;
          if (dcnt == CW'(1)) begin
            state_nxt   = RUN;
            cur_dir_nxt = target_dir;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    if (!en) begin
      duty_nxt = '0;
      if (state != DEAD) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cur_dir <= 1'b1;
      duty    <= '0;
      dcnt    <= '0;
      in_pair <= IN_FWD;
      settled <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state   <= state_nxt;
      cur_dir <= cur_dir_nxt;
      duty    <= duty_nxt;
      dcnt    <= dcnt_nxt;
      in_pair <= (state_nxt == DEAD) ? IN_OFF : in_enc(cur_dir_nxt);
      settled <= en && (state_nxt == RUN) && (duty_nxt == tgt) &&
                 (cur_dir_nxt == target_dir);
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// N-channel DC motor drive controller. A shared prescaler produces the ramp
// tick; each channel ramps its duty toward the target and reverses direction
// through decel -> dead time -> re-energise.
// Ports:
//  clk, rst     clock, async active-high reset
//  en           drive enable; 0 = immediate stop
//  target_duty  per-channel requested duty, ch i at [i*DUTY_W +: DUTY_W]
//  target_dir   per-channel requested direction, 1 = forward
//  duty_out     per-channel ramped duty to the PWM generators
//  in_pair      per-channel H-bridge IN pins, ch i at [2*i +: 2]
//  settled      per-channel "at target" flag
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DUTY_W     = 10,
  parameter int MAX_DUTY   = 1023,
  parameter int STEP       = 10,
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_TICKS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH*DUTY_W-1:0] target_duty,
  input  logic [NCH-1:0]        target_dir,
  output logic [NCH*DUTY_W-1:0] duty_out,
  output logic [2*NCH-1:0]      in_pair,
  output logic [NCH-1:0]        settled
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  // Free-running, including while disabled, so tick phase never depends on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pre <= '0;
    else if (pre == PRE_LAST) pre <= '0;
    else                  pre <= pre + 1'b1;
  end

  assign tick = (pre == PRE_LAST);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    motor_ramp_chan #(
      .DUTY_W     (DUTY_W),
      .MAX_DUTY   (MAX_DUTY),
      .STEP       (STEP),
      .DEAD_TICKS (DEAD_TICKS)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .tick        (tick),
      .target_duty (target_duty[i*DUTY_W +: DUTY_W]),
      .target_dir  (target_dir[i]),
      .duty        (duty_out[i*DUTY_W +: DUTY_W]),
      .in_pair     (in_pair[2*i +: 2]),
      .settled     (settled[i])
    );
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: directed scenarios followed by
// randomized targets/directions/enable, all compared every cycle against a
// behavioural per-channel model.
module tb_motor_ramp_ctrl;

  localparam int NCH        = 2;
  localparam int DUTY_W     = 10;
  localparam int MAX_DUTY   = 900;
  localparam int STEP       = 10;
  localparam int TICK_DIV   = 4;
  localparam int DEAD_TICKS = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en  = 1'b0;
  logic [NCH*DUTY_W-1:0] target_duty = '0;
  logic [NCH-1:0]        target_dir  = '1;
  logic [NCH*DUTY_W-1:0] duty_out;
  logic [2*NCH-1:0]      in_pair;
  logic [NCH-1:0]        settled;

  motor_ramp_ctrl #(
    .NCH(NCH), .DUTY_W(DUTY_W), .MAX_DUTY(MAX_DUTY), .STEP(STEP),
    .TICK_DIV(TICK_DIV), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .target_duty(target_duty),
    .target_dir(target_dir), .duty_out(duty_out), .in_pair(in_pair),
    .settled(settled)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per channel, a duty value, the direction the bridge is
  // driving, whether it is winding down for a reversal, and how many dead
  // ticks remain (non-zero means the bridge is off).
  int m_pre;
  int m_duty[NCH];
  bit m_dir[NCH];
  bit m_decel[NCH];
  int m_dead[NCH];
  bit m_set[NCH];
  bit off_seen0;

  function automatic int approach(input int cur, input int dst);
    int d = (dst > cur) ? dst - cur : cur - dst;
    if (d <= STEP) return dst;
    return (dst > cur) ? cur + STEP : cur - STEP;
  endfunction

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < NCH; c++) begin
      m_duty[c] = 0; m_dir[c] = 1'b1; m_decel[c] = 1'b0;
      m_dead[c] = 0; m_set[c] = 1'b0;
    end
  endtask

  task automatic model_step(input int c, input bit tk);
    int tgt;
    bit tdir;
    tgt  = int'(target_duty[c*DUTY_W +: DUTY_W]);
    if (tgt > MAX_DUTY) tgt = MAX_DUTY;
    tdir = target_dir[c];
    if (m_dead[c] > 0) begin
      if (tk) begin
        m_dead[c]--;
        if (m_dead[c] == 0) m_dir[c] = tdir;
      end
      m_duty[c] = 0;
    end else if (!en) begin
      m_duty[c]  = 0;
      m_decel[c] = 1'b0;
    end else if (tk) begin
      if (tdir != m_dir[c]) begin
        if (!m_decel[c]) begin
          if (m_duty[c] == 0) m_dead[c] = DEAD_TICKS;
          else                m_decel[c] = 1'b1;
        end else begin
          m_duty[c] = approach(m_duty[c], 0);
          if (m_duty[c] == 0) begin
            m_decel[c] = 1'b0;
            m_dead[c]  = DEAD_TICKS;
          end
        end
      end else if (m_decel[c]) begin
        m_decel[c] = 1'b0;
      end else begin
        m_duty[c] = approach(m_duty[c], tgt);
      end
    end
    m_set[c] = en && !m_decel[c] && (m_dead[c] == 0) && (m_duty[c] == tgt) &&
               (m_dir[c] == tdir);
  endtask

  task automatic compare_all();
    logic [NCH*DUTY_W-1:0] ed;
    logic [2*NCH-1:0]      ei;
    logic [NCH-1:0]        es;
    for (int c = 0; c < NCH; c++) begin
      ed[c*DUTY_W +: DUTY_W] = DUTY_W'(m_duty[c]);
      ei[2*c +: 2]           = (m_dead[c] > 0) ? 2'b00 : (m_dir[c] ? 2'b10 : 2'b01);
      es[c]                  = m_set[c];
    end
    check("duty_out", 32'(duty_out), 32'(ed));
    check("in_pair",  32'(in_pair),  32'(ei));
    check("settled",  32'(settled),  32'(es));
  endtask

  // One clock: advance the model on the same edge as the DUT, then compare.
  task automatic cycle(output bit tk);
    @(posedge clk);
    tk    = (m_pre == TICK_DIV - 1);
    m_pre = tk ? 0 : m_pre + 1;
    for (int c = 0; c < NCH; c++) model_step(c, tk);
    #1;
    if (in_pair[1:0] == 2'b00) off_seen0 = 1'b1;
    compare_all();
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    int budget = (n + 1) * TICK_DIV;
    bit tk;
    while (seen < n && budget > 0) begin
      cycle(tk);
      if (tk) seen++;
      budget--;
    end
    check("tick_budget", 32'(seen), 32'(n));
  endtask

  task automatic set_ch(input int c, input int d, input bit dir);
    target_duty[c*DUTY_W +: DUTY_W] = DUTY_W'(d);
    target_dir[c] = dir;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_duty",    32'(duty_out), 32'd0);
    check("rst_in_pair", 32'(in_pair),  32'b1010);
    check("rst_settled", 32'(settled),  32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit tk;
    model_reset();
    #2;
    apply_reset();
    en = 1'b1;

    // Ramp-up: 755 forward is 75 steps of +10 then one of +5.
    set_ch(0, 755, 1'b1);
    set_ch(1, 0, 1'b1);
    run_ticks(75);
    check("ramp_750",  32'(duty_out[9:0]), 32'd750);
    check("ramp_nset", 32'(settled[0]),    32'd0);
    run_ticks(1);
    check("ramp_755",  32'(duty_out[9:0]), 32'd755);
    check("ramp_set",  32'(settled[0]),    32'd1);

    // Reversal: 750 fwd -> 0 -> 3 dead ticks -> 750 rev.
    set_ch(0, 750, 1'b1);
    run_ticks(1);
    set_ch(0, 750, 1'b0);
    run_ticks(1);
    check("rev_decel_duty", 32'(duty_out[9:0]), 32'd750);
    check("rev_decel_in",   32'(in_pair[1:0]),  32'b10);
    run_ticks(75);
    check("rev_zero",       32'(duty_out[9:0]), 32'd0);
    check("rev_dead_in",    32'(in_pair[1:0]),  32'b00);
    run_ticks(2);
    check("rev_dead_hold",  32'(in_pair[1:0]),  32'b00);
    run_ticks(1);
    check("rev_energise",   32'(in_pair[1:0]),  32'b01);
    run_ticks(75);
    check("rev_750",        32'(duty_out[9:0]), 32'd750);
    check("rev_set",        32'(settled[0]),    32'd1);

    // Abort: reverse request withdrawn at 400, bridge must never go off.
    off_seen0 = 1'b0;
    set_ch(0, 750, 1'b1);
    run_ticks(36);
    check("abort_400", 32'(duty_out[9:0]), 32'd400);
    set_ch(0, 750, 1'b0);
    run_ticks(36);
    check("abort_750",    32'(duty_out[9:0]), 32'd750);
    check("abort_no_off", 32'(off_seen0),     32'd0);

    // Enable drop mid-ramp.
    set_ch(0, 200, 1'b0);
    set_ch(1, 300, 1'b1);
    run_ticks(5);
    en = 1'b0;
    cycle(tk);
    check("en0_duty",    32'(duty_out), 32'd0);
    check("en0_in_pair", 32'(in_pair),  32'b1001);
    run_ticks(3);
    check("en0_hold",    32'(duty_out), 32'd0);
    check("en0_settled", 32'(settled),  32'd0);
    en = 1'b1;
    run_ticks(1);
    check("en1_resume",  32'(duty_out), 32'({10'd10, 10'd10}));

    // Clamp and independence.
    set_ch(1, 1023, 1'b1);
    run_ticks(100);
    check("clamp_ch1", 32'(duty_out[19:10]), 32'd900);
    check("clamp_ch0", 32'(duty_out[9:0]),   32'd200);
    check("clamp_set", 32'(settled),         32'b11);

    // Reset mid-ramp.
    set_ch(0, 500, 1'b0);
    run_ticks(10);
    apply_reset();

    // Randomized traffic.
    for (int k = 0; k < 1600; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0)
          target_duty[c*DUTY_W +: DUTY_W] = DUTY_W'($urandom_range(0, 1023));
        if ($urandom_range(0, 59) == 0)
          target_dir[c] = ~target_dir[c];
      end
      if ($urandom_range(0, 79) == 0) en = ~en;
      if (k == 800) apply_reset();
      cycle(tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
